buffer_to_mpf_wr_engine: RTL

Write-side streaming engine for the generic processing AFU. It drains 512-bit cache lines from the 64-to-512 write buffer and issues one line write per line to consecutive host line addresses through the MPF c1 channel. It also counts write responses and pulses `done` once every line has been acknowledged. It is the mirror of the read-side memory-to-buffer engine and consumes what the write buffer produces.

---
 rtl/buffer_to_mpf_wr_engine.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/buffer_to_mpf_wr_engine.sv
// buffer_to_mpf_wr_engine
// Write-side streaming engine. Drains 512-bit lines from the write buffer
// (show-ahead FIFO) and issues one c1 line write per line to consecutive host
// line addresses. It counts write responses and pulses done once every issued
// line has been acknowledged.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   run                 start pulse, sampled only in IDLE
//   first_clAddr        line address of line 0, latched on an accepted run
//   data_length         transfer length in bytes, latched on an accepted run
//   buf_data/buf_empty  head line of the write buffer / buffer has no line
//   buf_rd_enable       pops the buffer head this cycle (combinational)
//   c1_almfull          c1 channel almost full, blocks issue in the same cycle
//   c1_tx_valid/addr/data  registered line-write request
//   c1_rx_wr_rsp        one single-line write response
//   busy                high while in ISSUE or DRAIN
//   done                one-cycle completion pulse
//   dbg_state           current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE)
//
// Handshake: buffer lines are consumed with show-ahead semantics -- buf_data is
// valid whenever buf_empty is low, and the line is taken in the same cycle
// buf_rd_enable is high. The request presented on c1 in the next cycle carries
// exactly the buf_data value seen on the pop cycle. The c1 side has no ready;
// flow control is c1_almfull plus the outstanding-write limit.
`timescale 1ns/1ps
module buffer_to_mpf_wr_engine #(
  parameter int ADDR_W          = 42,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] first_clAddr,
  input  logic [63:0]       data_length,
  input  logic [511:0]      buf_data,
  input  logic              buf_empty,
  output logic              buf_rd_enable,
  input  logic              c1_almfull,
  output logic              c1_tx_valid,
  output logic [ADDR_W-1:0] c1_tx_addr,
  output logic [511:0]      c1_tx_data,
  input  logic              c1_rx_wr_rsp,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int               CNT_W   = 58;
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   acked_q, acked_d;
  logic               tx_valid_q;
  logic [ADDR_W-1:0]  tx_addr_q;
  logic [511:0]       tx_data_q;
  logic               busy_q;
  logic               done_q;

  logic [CNT_W-1:0]   req_total;
  logic [CNT_W-1:0]   outstanding;
  logic               fire;
  logic               rsp_count;

  // A partial last line still needs a whole line write.
  assign req_total   = data_length[63:6] + {{(CNT_W-1){1'b0}}, |data_length[5:0]};
  assign outstanding = issued_q - acked_q;

  assign fire = (state_q == S_ISSUE) && !buf_empty && !c1_almfull &&
                (outstanding < MAX_OUT) && (issued_q < total_q);

  // Responses only belong to a transfer in flight; stray ones after an
  // aborted transfer land in IDLE and are dropped.
  assign rsp_count = c1_rx_wr_rsp && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  assign buf_rd_enable = fire && !reset;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    total_d  = total_q;
    issued_d = issued_q + CNT_W'(fire);
    acked_d  = acked_q + CNT_W'(rsp_count);
    case (state_q)
      S_IDLE: begin
        if (run) begin
          base_d   = first_clAddr;
          total_d  = req_total;
          issued_d = '0;
          acked_d  = '0;
          state_d  = (req_total == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire && (issued_d == total_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Compare the post-increment count so the last response moves us to
        // DONE on the very next cycle.
        if (acked_d == total_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      acked_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      acked_q    <= acked_d;
      tx_valid_q <= fire;
      if (fire) begin
        tx_addr_q <= base_q + ADDR_W'(issued_q);
        tx_data_q <= buf_data;
      end
      busy_q     <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign c1_tx_valid = tx_valid_q;
  assign c1_tx_addr  = tx_addr_q;
  assign c1_tx_data  = tx_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
